// File: rtl/approx_mult8_pipe.sv
// approx_mult8_pipe: two-stage 8x8 unsigned multiplier. Low partial-product
// columns are OR-collapsed (no carries); high columns are summed exactly.
module approx_mult8_pipe #(
    parameter int APPROX_COLS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        out_valid,
    output logic [15:0] y
);

    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic        v1_q;
    logic [15:0] y_q;
    logic [15:0] y_d;
    logic        v2_q;

    logic [15:0] lo;
    logic [15:0] row [8];

    function automatic logic [15:0] csa_s(
        input logic [15:0] p,
        input logic [15:0] q,
        input logic [15:0] r
    );
        return p ^ q ^ r;
    endfunction

    function automatic logic [15:0] csa_c(
        input logic [15:0] p,
        input logic [15:0] q,
        input logic [15:0] r
    );
        return ((p & q) | (p & r) | (q & r)) << 1;
    endfunction

    // Each partial product lands either in the OR-collapsed low word or in
    // its own row of the exact sum; the two sets occupy disjoint columns.
    always_comb begin
        lo = '0;
        for (int i = 0; i < 8; i++) begin
            row[i] = '0;
            for (int j = 0; j < 8; j++) begin
                if (i + j < APPROX_COLS)
                    lo[i+j] = lo[i+j] | (a_q[j] & b_q[i]);
                else
                    row[i][i+j] = a_q[j] & b_q[i];
            end
        end
    end

    logic [15:0] s0, c0, s1, c1, s2, c2;
    logic [15:0] s3, c3, s4, c4;
    logic [15:0] s5, c5, s6, c6;

    // Carry-save tree over 9 operands; the true total stays below 2^16,
    // so dropping carries out of bit 15 never changes the result.
    assign s0 = csa_s(row[0], row[1], row[2]);
    assign c0 = csa_c(row[0], row[1], row[2]);
    assign s1 = csa_s(row[3], row[4], row[5]);
    assign c1 = csa_c(row[3], row[4], row[5]);
    assign s2 = csa_s(row[6], row[7], lo);
    assign c2 = csa_c(row[6], row[7], lo);

    assign s3 = csa_s(s0, c0, s1);
    assign c3 = csa_c(s0, c0, s1);
    assign s4 = csa_s(c1, s2, c2);
    assign c4 = csa_c(c1, s2, c2);

    assign s5 = csa_s(s3, c3, s4);
    assign c5 = csa_c(s3, c3, s4);
    assign s6 = csa_s(s5, c5, c4);
    assign c6 = csa_c(s5, c5, c4);

    assign y_d = s6 + c6;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            y_q  <= '0;
            v2_q <= 1'b0;
        end else begin
            a_q  <= A;
            b_q  <= B;
            v1_q <= in_valid;
            y_q  <= y_d;
            v2_q <= v1_q;
        end
    end

    assign y         = y_q;
    assign out_valid = v2_q;

endmodule

// File: tb/tb_approx_mult8_pipe.sv
// Scoreboard bench for approx_mult8_pipe: APPROX_COLS=8 instance checked
// against directed/model values, APPROX_COLS=0 instance against A*B.
module tb_approx_mult8_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_v = 1'b0;
    logic [7:0]  a_s = '0;
    logic [7:0]  b_s = '0;
    logic        ov8, ov0;
    logic [15:0] y8, y0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] ea;
        logic [15:0] ex;
        int          cyc;
        logic [7:0]  a;
        logic [7:0]  b;
    } ent_t;

    ent_t sq[$];

    approx_mult8_pipe #(.APPROX_COLS(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_v),
        .A(a_s), .B(b_s), .out_valid(ov8), .y(y8)
    );

    approx_mult8_pipe #(.APPROX_COLS(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_v),
        .A(a_s), .B(b_s), .out_valid(ov0), .y(y0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Column-count reference: OR below ac, exact weighted sum at and above.
    function automatic logic [15:0] model(
        input logic [7:0] a,
        input logic [7:0] b,
        input int         ac
    );
        logic [15:0] l;
        int          h;
        int          cnt;
        l = '0;
        h = 0;
        for (int k = 0; k < 15; k++) begin
            cnt = 0;
            for (int i = 0; i < 8; i++)
                if (k - i >= 0 && k - i < 8)
                    cnt += int'(a[k-i] & b[i]);
            if (k < ac) begin
                if (cnt > 0) l[k] = 1'b1;
            end else begin
                h += cnt << k;
            end
        end
        return l + h[15:0];
    endfunction

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic v, input logic [15:0] ea);
        ent_t e;
        @(negedge clk);
        #1;
        a_s  = a;
        b_s  = b;
        in_v = v;
        if (v) begin
            e.ea  = ea;
            e.ex  = 16'(a) * 16'(b);
            e.cyc = cyc;
            e.a   = a;
            e.b   = b;
            sq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (!rst) begin
            if (ov8 !== ov0) begin
                n_vec++;
                n_err++;
                $display("FAIL valid_pair: ov8 %b ov0 %b", ov8, ov0);
            end
            if (ov8 === 1'b1) begin
                n_vec++;
                if (sq.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_valid: y %h at cyc %0d", y8, cyc);
                end else begin
                    e = sq.pop_front();
                    if (y8 !== e.ea || y0 !== e.ex || y8 > e.ex ||
                        cyc != e.cyc + 2) begin
                        n_err++;
                        $display("FAIL vec %h*%h: y8 %h want %h, y0 %h want %h, lat %0d want 2",
                                 e.a, e.b, y8, e.ea, y0, e.ex, cyc - e.cyc);
                    end
                end
            end else if (sq.size() != 0 && sq[0].cyc + 2 <= cyc) begin
                e = sq.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missing_valid: %h*%h got out_valid %b want 1",
                         e.a, e.b, ov8);
            end
        end
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rv;

        #1 rst = 1'b1;
        #2;
        chk("reset_y8", y8, 16'h0000);
        chk("reset_y0", y0, 16'h0000);
        chk("reset_v8", {15'd0, ov8}, 16'h0000);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        issue(8'h80, 8'hFF, 1'b1, 16'h7F80);
        issue(8'h80, 8'h40, 1'b1, 16'h2000);
        issue(8'hFF, 8'hFF, 1'b1, 16'hF7FF);
        issue(8'h03, 8'h03, 1'b1, 16'h0007);
        issue(8'h10, 8'h10, 1'b1, 16'h0100);
        issue(8'h00, 8'hA5, 1'b1, 16'h0000);
        issue(8'h11, 8'h22, 1'b0, 16'h0000);
        issue(8'h01, 8'hC3, 1'b1, 16'h00C3);

        for (int i = 0; i < 256; i++)
            issue(8'h80, 8'(i), 1'b1, 16'(i) << 7);

        // Mid-stream asynchronous reset between edges.
        for (int i = 0; i < 4; i++)
            issue(8'h80, 8'(i + 1), 1'b1, 16'(i + 1) << 7);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", {15'd0, ov8}, 16'h0001);
        rst = 1'b1;
        sq.delete();
        #1;
        chk("async_rst_y", y8, 16'h0000);
        chk("async_rst_v", {15'd0, ov8}, 16'h0000);
        in_v = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(8'h55, 8'h55, 1'b0, 16'h0000);
            chk("idle_valid", {15'd0, ov8}, 16'h0000);
        end
        issue(8'h80, 8'h02, 1'b1, 16'h0100);
        issue(8'h00, 8'h00, 1'b0, 16'h0000);

        for (int i = 0; i < 10000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rv = 1'($urandom_range(0, 3) != 0);
            issue(ra, rb, rv, model(ra, rb, 8));
        end
        issue(8'h00, 8'h00, 1'b0, 16'h0000);

        for (int i = 0; i < 10 && sq.size() != 0; i++)
            @(negedge clk);
        #1;
        if (sq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results outstanding, want 0", sq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
